// File: rtl/mips_writeback.sv
// MEM/WB retirement stage: queues retiring instructions, waits for load data and drives the register file write port.
// Optional retirement counter output enabled by defining WB_RETIRE_CNT_EN.
module mips_writeback #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_reg_write,
    input  logic            in_reg_dest,
    input  logic [4:0]      in_rt,
    input  logic [4:0]      in_rd,
    input  logic            in_mem_to_reg,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic            mem_rdata_valid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            wb_reg_write,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_write_data,
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data,
`ifdef WB_RETIRE_CNT_EN
    output logic [31:0]     retire_count,
`endif
    output logic            err_stray_load
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_LOAD = 2'd1;
    localparam logic [1:0] S_WRITE     = 2'd2;

    logic [4:0]      dest_q [DEPTH];
    logic [4:0]      dest_d [DEPTH];
    logic            rw_q   [DEPTH];
    logic            rw_d   [DEPTH];
    logic            m2r_q  [DEPTH];
    logic            m2r_d  [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [XLEN-1:0] data_d [DEPTH];

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [1:0]      state_q, state_d;
    logic            wb_reg_write_q, wb_reg_write_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            err_q, err_d;

    logic            push_s;
    logic            pop_s;
    logic [AW-1:0]   next_idx_s;
    logic [4:0]      head_dest_s;
    logic            head_rw_s;
    logic            head_m2r_s;
    logic [XLEN-1:0] head_data_s;

    assign in_ready    = (count_q < CW'(DEPTH));
    assign push_s      = in_valid && in_ready;
    assign pop_s       = (state_q == S_WRITE);
    assign next_idx_s  = rd_ptr_q + AW'(1);
    assign head_dest_s = dest_q[rd_ptr_q];
    assign head_rw_s   = rw_q[rd_ptr_q];
    assign head_m2r_s  = m2r_q[rd_ptr_q];
    assign head_data_s = data_q[rd_ptr_q];

    assign fwd_valid      = (state_q == S_WRITE) && head_rw_s && (head_dest_s != 5'd0);
    assign fwd_rd         = head_dest_s;
    assign fwd_data       = head_data_s;
    assign wb_reg_write   = wb_reg_write_q;
    assign wb_rd          = wb_rd_q;
    assign wb_write_data  = wb_data_q;
    assign err_stray_load = err_q;

    // Queue storage, pointers, head FSM and write-port next-state logic
    always_comb begin
        dest_d         = dest_q;
        rw_d           = rw_q;
        m2r_d          = m2r_q;
        data_d         = data_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        state_d        = state_q;
        wb_reg_write_d = 1'b0;
        wb_rd_d        = wb_rd_q;
        wb_data_d      = wb_data_q;
        count_d        = count_q + CW'(push_s) - CW'(pop_s);
        err_d          = err_q | (mem_rdata_valid && (state_q != S_WAIT_LOAD));

        if (push_s) begin
            dest_d[wr_ptr_q] = in_reg_dest ? in_rd : in_rt;
            rw_d[wr_ptr_q]   = in_reg_write;
            m2r_d[wr_ptr_q]  = in_mem_to_reg;
            data_d[wr_ptr_q] = in_alu_result;
            wr_ptr_d         = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        case (state_q)
            S_IDLE: begin
                // An empty queue lets a fresh push go straight to its first state
                if (count_q != CW'(0)) begin
                    state_d = head_m2r_s ? S_WAIT_LOAD : S_WRITE;
                end else if (push_s) begin
                    state_d = in_mem_to_reg ? S_WAIT_LOAD : S_WRITE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_LOAD: begin
                if (mem_rdata_valid) begin
                    data_d[rd_ptr_q] = mem_rdata;
                    state_d          = S_WRITE;
                end else begin
                    state_d = S_WAIT_LOAD;
                end
            end
            S_WRITE: begin
                rd_ptr_d       = next_idx_s;
                wb_reg_write_d = head_rw_s && (head_dest_s != 5'd0);
                wb_rd_d        = head_dest_s;
                wb_data_d      = head_data_s;
                if (count_q > CW'(1)) begin
                    state_d = m2r_q[next_idx_s] ? S_WAIT_LOAD : S_WRITE;
                end else if (push_s) begin
                    state_d = in_mem_to_reg ? S_WAIT_LOAD : S_WRITE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                dest_q[i] <= 5'd0;
                rw_q[i]   <= 1'b0;
                m2r_q[i]  <= 1'b0;
                data_q[i] <= '0;
            end
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            state_q        <= S_IDLE;
            wb_reg_write_q <= 1'b0;
            wb_rd_q        <= 5'd0;
            wb_data_q      <= '0;
            err_q          <= 1'b0;
        end else begin
            dest_q         <= dest_d;
            rw_q           <= rw_d;
            m2r_q          <= m2r_d;
            data_q         <= data_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            state_q        <= state_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
            err_q          <= err_d;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt_q, retire_cnt_d;

    // Every WRITE cycle is one retirement, suppressed writes included
    always_comb begin
        if (state_q == S_WRITE) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end else begin
            retire_cnt_d = retire_cnt_q;
        end
    end

    // Retirement counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retire_cnt_q <= 32'd0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retire_count = retire_cnt_q;
`endif

endmodule

// File: tb/tb_mips_writeback.sv
// Directed self-checking bench for mips_writeback (DEPTH=2, XLEN=32).
module tb_mips_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_reg_write;
    logic        in_reg_dest;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic        in_mem_to_reg;
    logic [31:0] in_alu_result;
    logic        mem_rdata_valid;
    logic [31:0] mem_rdata;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_write_data;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        err_stray_load;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    mips_writeback #(.DEPTH(2), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_reg_write(in_reg_write), .in_reg_dest(in_reg_dest),
        .in_rt(in_rt), .in_rd(in_rd), .in_mem_to_reg(in_mem_to_reg),
        .in_alu_result(in_alu_result),
        .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_write_data(wb_write_data),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
`ifdef WB_RETIRE_CNT_EN
        .retire_count(retire_count),
`endif
        .err_stray_load(err_stray_load)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic rw, input logic rdst, input logic [4:0] rt,
                          input logic [4:0] rd, input logic m2r, input logic [31:0] alu);
        in_valid      = 1'b1;
        in_reg_write  = rw;
        in_reg_dest   = rdst;
        in_rt         = rt;
        in_rd         = rd;
        in_mem_to_reg = m2r;
        in_alu_result = alu;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_reg_write = 1'b0; in_reg_dest = 1'b0;
        in_rt = 5'd0; in_rd = 5'd0; in_mem_to_reg = 1'b0; in_alu_result = 32'd0;
        mem_rdata_valid = 1'b0; mem_rdata = 32'd0;
        step(); step();
        rst_n = 1'b1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++;
        if ({wb_reg_write, wb_rd, wb_write_data} !== 38'd0) begin
            n_fail++; $display("FAIL reset_wb: got %b/%0d/%h expected 0/0/0", wb_reg_write, wb_rd, wb_write_data);
        end
        n_checks++;
        if ({fwd_valid, fwd_rd, fwd_data, err_stray_load} !== 39'd0) begin
            n_fail++; $display("FAIL reset_fwd_err: got %b/%0d/%h/%b expected all 0", fwd_valid, fwd_rd, fwd_data, err_stray_load);
        end
`ifdef WB_RETIRE_CNT_EN
        n_checks++;
        if (retire_count !== 32'd0) begin n_fail++; $display("FAIL reset_retire_count: got %0d expected 0", retire_count); end
`endif
    endtask

    task automatic test_alu_single();
        set_op(1'b1, 1'b1, 5'd3, 5'd8, 1'b0, 32'h0000_1234);
        step();
        in_valid = 1'b0;
        n_checks++;
        if (wb_reg_write !== 1'b0) begin n_fail++; $display("FAIL alu_early_pulse: got %b expected 0", wb_reg_write); end
        n_checks++;
        if ({fwd_valid, fwd_rd, fwd_data} !== {1'b1, 5'd8, 32'h0000_1234}) begin
            n_fail++; $display("FAIL alu_fwd: got %b/%0d/%h expected 1/8/00001234", fwd_valid, fwd_rd, fwd_data);
        end
        step();
        n_checks++;
        if ({wb_reg_write, wb_rd, wb_write_data} !== {1'b1, 5'd8, 32'h0000_1234}) begin
            n_fail++; $display("FAIL alu_pulse: got %b/%0d/%h expected 1/8/00001234", wb_reg_write, wb_rd, wb_write_data);
        end
        step();
        n_checks++;
        if ({wb_reg_write, wb_rd, wb_write_data} !== {1'b0, 5'd8, 32'h0000_1234}) begin
            n_fail++; $display("FAIL alu_hold: got %b/%0d/%h expected 0/8/00001234", wb_reg_write, wb_rd, wb_write_data);
        end
    endtask

    task automatic test_load_wait();
        set_op(1'b1, 1'b0, 5'd9, 5'd5, 1'b1, 32'h5555_5555);
        step();
        set_op(1'b1, 1'b1, 5'd1, 5'd10, 1'b0, 32'h0000_000A);
        step();
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL load_full_ready: got %b expected 0", in_ready); end
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if ({wb_reg_write, fwd_valid} !== 2'b00) begin
                n_fail++; $display("FAIL load_wait_cycle%0d: got wb=%b fwd=%b expected 0/0", i, wb_reg_write, fwd_valid);
            end
        end
        mem_rdata_valid = 1'b1;
        mem_rdata       = 32'hDEAD_BEEF;
        step();
        mem_rdata_valid = 1'b0;
        mem_rdata       = 32'd0;
        n_checks++;
        if ({wb_reg_write, fwd_valid, fwd_rd, fwd_data} !== {1'b0, 1'b1, 5'd9, 32'hDEAD_BEEF}) begin
            n_fail++; $display("FAIL load_beat: got wb=%b fwd=%b/%0d/%h expected 0 1/9/deadbeef", wb_reg_write, fwd_valid, fwd_rd, fwd_data);
        end
        step();
        n_checks++;
        if ({wb_reg_write, wb_rd, wb_write_data} !== {1'b1, 5'd9, 32'hDEAD_BEEF}) begin
            n_fail++; $display("FAIL load_pulse: got %b/%0d/%h expected 1/9/deadbeef", wb_reg_write, wb_rd, wb_write_data);
        end
        step();
        n_checks++;
        if ({wb_reg_write, wb_rd, wb_write_data} !== {1'b1, 5'd10, 32'h0000_000A}) begin
            n_fail++; $display("FAIL load_next_alu: got %b/%0d/%h expected 1/10/0000000a", wb_reg_write, wb_rd, wb_write_data);
        end
        step();
        n_checks++;
        if ({wb_reg_write, in_ready, err_stray_load} !== 3'b010) begin
            n_fail++; $display("FAIL load_drain: got wb=%b ready=%b err=%b expected 0/1/0", wb_reg_write, in_ready, err_stray_load);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            set_op(1'b1, 1'b1, 5'd0, 5'(i + 1), 1'b0, 32'h100 + 32'(i));
            step();
            n_checks++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready%0d: got %b expected 1", i, in_ready); end
            if (i > 0) begin
                n_checks++;
                if ({wb_reg_write, wb_rd, wb_write_data} !== {1'b1, 5'(i), 32'h100 + 32'(i - 1)}) begin
                    n_fail++; $display("FAIL b2b_pulse%0d: got %b/%0d/%h expected 1/%0d/%h", i, wb_reg_write, wb_rd, wb_write_data, i, 32'h100 + 32'(i - 1));
                end
            end
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if ({wb_reg_write, wb_rd, wb_write_data} !== {1'b1, 5'd4, 32'h0000_0103}) begin
            n_fail++; $display("FAIL b2b_pulse4: got %b/%0d/%h expected 1/4/00000103", wb_reg_write, wb_rd, wb_write_data);
        end
        step();
        n_checks++;
        if (wb_reg_write !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got %b expected 0", wb_reg_write); end
    endtask

    task automatic test_zero_dest();
        test_reset();
        set_op(1'b1, 1'b1, 5'd7, 5'd0, 1'b0, 32'h0000_0077);
        step();
        set_op(1'b0, 1'b1, 5'd7, 5'd6, 1'b0, 32'h0000_0088);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({wb_reg_write, fwd_valid} !== 2'b00) begin
                n_fail++; $display("FAIL zero_no_pulse%0d: got wb=%b fwd=%b expected 0/0", i, wb_reg_write, fwd_valid);
            end
            step();
        end
`ifdef WB_RETIRE_CNT_EN
        n_checks++;
        if (retire_count !== 32'd2) begin n_fail++; $display("FAIL zero_retire_count: got %0d expected 2", retire_count); end
`endif
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL zero_drained: got %b expected 1", in_ready); end
    endtask

    task automatic test_stray_load();
        mem_rdata_valid = 1'b1;
        mem_rdata       = 32'h1111_1111;
        step();
        mem_rdata_valid = 1'b0;
        n_checks++;
        if ({err_stray_load, wb_reg_write} !== 2'b10) begin
            n_fail++; $display("FAIL stray_set: got err=%b wb=%b expected 1/0", err_stray_load, wb_reg_write);
        end
        step(); step(); step();
        n_checks++;
        if ({err_stray_load, wb_reg_write, in_ready} !== 3'b101) begin
            n_fail++; $display("FAIL stray_sticky: got err=%b wb=%b ready=%b expected 1/0/1", err_stray_load, wb_reg_write, in_ready);
        end
    endtask

    task automatic test_mid_reset();
        set_op(1'b1, 1'b0, 5'd12, 5'd2, 1'b1, 32'h0000_0C0C);
        step();
        set_op(1'b1, 1'b1, 5'd2, 5'd13, 1'b0, 32'h0000_0D0D);
        step();
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_full: got %b expected 0", in_ready); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_checks++;
        if ({in_ready, wb_reg_write, fwd_valid, err_stray_load} !== 4'b1000) begin
            n_fail++; $display("FAIL midrst_state: got ready=%b wb=%b fwd=%b err=%b expected 1/0/0/0", in_ready, wb_reg_write, fwd_valid, err_stray_load);
        end
        mem_rdata_valid = 1'b1;
        mem_rdata       = 32'hCAFE_F00D;
        step();
        mem_rdata_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({wb_reg_write, fwd_valid} !== 2'b00) begin
                n_fail++; $display("FAIL midrst_no_write%0d: got wb=%b fwd=%b expected 0/0", i, wb_reg_write, fwd_valid);
            end
        end
        n_checks++;
        if ({err_stray_load, in_ready} !== 2'b11) begin
            n_fail++; $display("FAIL midrst_stray: got err=%b ready=%b expected 1/1", err_stray_load, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_alu_single();
        test_load_wait();
        test_back_to_back();
        test_zero_dest();
        test_stray_load();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_writeback.md
Name: mips_writeback

Overview:
- Writer side of the 32x32 MIPS register file: MEM/WB retirement stage.
- Buffers retiring instructions from MEM, waits for late load data, selects the destination (rt/rd) and data (ALU/load).
- Issues exactly one write pulse per writing instruction into the register file's write port; exposes a forwarding tap for hazard logic.

Parameters:
- DEPTH, 2, retirement queue entries (power of two, >=2)
- XLEN, 32, data width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  MEM stage presents a retiring instruction
- in_ready  out  1  queue can accept (count < DEPTH)
- in_reg_write  in  1  instruction writes a register
- in_reg_dest  in  1  1: dest = in_rd, 0: dest = in_rt
- in_rt  in  5  rt field
- in_rd  in  5  rd field
- in_mem_to_reg  in  1  1: data comes from memory (load)
- in_alu_result  in  XLEN  ALU result
- mem_rdata_valid  in  1  load data beat for queue head
- mem_rdata  in  XLEN  load data
- wb_reg_write  out  1  register file write enable (one-cycle pulse)
- wb_rd  out  5  register file write address
- wb_write_data  out  XLEN  register file write data
- fwd_valid  out  1  head entry has final data and a nonzero writing dest
- fwd_rd  out  5  head destination
- fwd_data  out  XLEN  head final data
- err_stray_load  out  1  sticky: mem_rdata_valid outside WAIT_LOAD

Behaviour:
- Reset (rst_n=0 at a clk edge): queue empty, state IDLE. All outputs 0 except in_ready=1. Mid-operation reset discards queued entries and any pending load; no write pulse in the following cycle.
- Accept: in_valid && in_ready at an edge pushes one entry. The entry holds dest (in_reg_dest ? in_rd : in_rt) resolved at push, reg_write, mem_to_reg and alu_result. Push while full is impossible: in_ready=0, and upstream holds.
- in_ready depends only on registered count; no same-cycle push-on-pop bypass.
- FSM on queue head:
  - IDLE: queue empty. On a nonempty queue, go to WRITE if head.mem_to_reg=0, else WAIT_LOAD.
  - WAIT_LOAD: on mem_rdata_valid, capture mem_rdata as head data and go to WRITE.
  - WRITE: pop head (exactly one cycle). Next state: WRITE if the new head is non-load, WAIT_LOAD if it is a load, IDLE if empty.
- Write port: wb_* are registered. The edge that leaves WRITE sets wb_reg_write = head.reg_write && (dest != 0), wb_rd = dest, wb_write_data = final data. Otherwise wb_reg_write=0; wb_rd and wb_write_data hold their last values.
- Latency: an ALU op pushed at edge N into an empty queue is in WRITE during cycle N..N+1 and pulses wb_reg_write during N+1..N+2. Throughput is 1 retirement/cycle for back-to-back non-load ops.
- $zero: dest 0 retires without a pulse. reg_write=0 retires without a pulse.
- Forwarding (combinational from head): fwd_valid=1 when state=WRITE && head.reg_write && dest!=0.
- mem_rdata_valid in any state other than WAIT_LOAD is dropped and sets err_stray_load. err_stray_load clears only on reset.
- Simultaneous push and pop: count is unchanged; pointers wrap modulo DEPTH.

Optional Feature:
- WB_RETIRE_CNT_EN defined: adds output retire_count (32 bits). It increments once per WRITE cycle (every retirement, including suppressed writes), resets to 0 and wraps from 0xFFFFFFFF to 0.
- Undefined: port and counter are absent; the rest of the behaviour is identical.

Test Plan:
- Reset, then push ALU op (reg_dest=1, rd=8, alu=0x0000_1234) into an empty queue -> exactly one wb_reg_write pulse 1 cycle later with wb_rd=8, wb_write_data=0x1234.
- Push load (reg_dest=0, rt=9) and hold mem_rdata_valid low for 5 cycles, then pulse it with 0xDEAD_BEEF -> no write while waiting; one pulse rd=9, data 0xDEADBEEF the cycle after the beat; in_ready=0 once DEPTH entries are queued.
- Push 4 back-to-back ALU ops (rd=1..4) -> 4 consecutive pulses in order, no gaps, and in_ready never deasserts.
- Push op with rd=0 and reg_write=1, then op with reg_write=0 -> both retire with no wb_reg_write pulse; with WB_RETIRE_CNT_EN, retire_count=2.
- Pulse mem_rdata_valid while the queue is empty -> err_stray_load=1 and stays 1; no write occurs.
- Assert rst_n=0 for one edge while a load sits in WAIT_LOAD with 2 entries queued -> queue empty, in_ready=1, and no write pulse afterwards even if mem_rdata_valid arrives.
